hazard_tracker: RTL

Register-tag scoreboard for the 5-stage ARM pipeline; the producer side of the hazard unit interface. Tracks decode-stage validity and per-stage register tags and control bits (E, M, W). Generates the 5-bit `match` vector and the per-stage `reg_write`, `mem_reg` and `pc_src` flags that the hazard unit consumes. Applies the hazard unit's `stall_d`, `flush_d` and `flush_e` back onto its own stage registers.

---
 rtl/hazard_tracker.sv | 110 +++++++++++
 1 files changed

// File: rtl/hazard_tracker.sv
// Register-tag scoreboard feeding the hazard unit: tracks D validity and E/M/W tags and controls.
// Optional build macro HAZARD_TRACKER_PC_MASK_EN suppresses every match that involves r15.
module hazard_tracker #(
    parameter int REG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] ra1_d,
    input  logic [REG_W-1:0] ra2_d,
    input  logic [REG_W-1:0] wa3_d,
    input  logic             reg_write_d,
    input  logic             mem_reg_d,
    input  logic             pc_src_d_raw,
    input  logic             cond_ex_e,
    input  logic             stall_d,
    input  logic             flush_d,
    input  logic             flush_e,
    output logic [4:0]       match,
    output logic             reg_write_m,
    output logic             reg_write_w,
    output logic             mem_reg_e,
    output logic             pc_src_d,
    output logic             pc_src_e,
    output logic             pc_src_m,
    output logic             pc_src_w,
    output logic [REG_W-1:0] wa3_m,
    output logic [REG_W-1:0] wa3_w
);

    logic             valid_d;
    logic             valid_e;
    logic [REG_W-1:0] ra1_e;
    logic [REG_W-1:0] ra2_e;
    logic [REG_W-1:0] wa3_e;
    logic             reg_write_e;

`ifdef HAZARD_TRACKER_PC_MASK_EN
    localparam logic [REG_W-1:0] PC_TAG = REG_W'(15);

    // PC reads come from the PC+8 path, so r15 never forwards.
    function automatic logic tag_eq(input logic [REG_W-1:0] src, input logic [REG_W-1:0] dst);
        return (src == dst) && (src != PC_TAG) && (dst != PC_TAG);
    endfunction
`else
    function automatic logic tag_eq(input logic [REG_W-1:0] src, input logic [REG_W-1:0] dst);
        return src == dst;
    endfunction
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_d <= 1'b0;
        end else if (flush_d) begin
            valid_d <= 1'b0;
        end else if (!stall_d) begin
            valid_d <= 1'b1;
        end
    end

    assign pc_src_d = pc_src_d_raw & valid_d;

    // E is never stalled; a load-use stall pairs stall_d with flush_e to inject a bubble.
    always_ff @(posedge clk) begin
        if (rst || flush_e) begin
            ra1_e       <= '0;
            ra2_e       <= '0;
            wa3_e       <= '0;
            reg_write_e <= 1'b0;
            mem_reg_e   <= 1'b0;
            pc_src_e    <= 1'b0;
            valid_e     <= 1'b0;
        end else begin
            ra1_e       <= ra1_d;
            ra2_e       <= ra2_d;
            wa3_e       <= wa3_d;
            reg_write_e <= reg_write_d & valid_d;
            mem_reg_e   <= mem_reg_d & valid_d;
            pc_src_e    <= pc_src_d;
            valid_e     <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            reg_write_m <= 1'b0;
            pc_src_m    <= 1'b0;
            wa3_m       <= '0;
            reg_write_w <= 1'b0;
            pc_src_w    <= 1'b0;
            wa3_w       <= '0;
        end else begin
            reg_write_m <= reg_write_e & cond_ex_e;
            pc_src_m    <= pc_src_e & cond_ex_e;
            wa3_m       <= wa3_e;
            reg_write_w <= reg_write_m;
            pc_src_w    <= pc_src_m;
            wa3_w       <= wa3_m;
        end
    end

    always_comb begin
        match    = '0;
        match[4] = reg_write_m & tag_eq(ra1_e, wa3_m);
        match[3] = reg_write_w & tag_eq(ra1_e, wa3_w);
        match[2] = reg_write_m & tag_eq(ra2_e, wa3_m);
        match[1] = reg_write_w & tag_eq(ra2_e, wa3_w);
        match[0] = valid_e & reg_write_e & (tag_eq(ra1_d, wa3_e) | tag_eq(ra2_d, wa3_e));
    end

endmodule
